// File: rtl/led_pwm_pkg.sv
// Shared defaults and helpers for the LED PWM driver.
package led_pwm_pkg;

    localparam int unsigned DEF_N_LEDS        = 8;
    localparam int unsigned DEF_PWM_BITS      = 8;
    localparam int unsigned DEF_PRESCALE      = 4;
    localparam int unsigned DEF_BLINK_PERIODS = 64;

    // Counter width needed to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, PWM counter, period wrap and registered period_start.
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEF_PWM_BITS,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                wrap_c,
    output logic                period_start
);

    localparam int unsigned     PS_W    = cnt_width(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                period_start_q, period_start_d;
    logic                tick_c;

    // Next-state: prescaler wraps at PRESCALE-1, PWM counter advances on tick.
    always_comb begin
        tick_c         = (prescaler_q == PS_LAST);
        prescaler_d    = prescaler_q + PS_W'(1);
        pwm_cnt_d      = pwm_cnt_q;
        wrap_c         = 1'b0;
        if (tick_c) begin
            prescaler_d = '0;
            pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
            wrap_c      = &pwm_cnt_q;
        end
        period_start_d = wrap_c;
    end

    // Timebase registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q    <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_cnt      = pwm_cnt_q;
    assign period_start = period_start_q;

endmodule

// File: rtl/led_pwm_driver.sv
// LED PWM driver: registers the LED pattern, gates it with a global PWM duty
// cycle and optional per-LED blinking. Blink is compiled in only when the
// macro LED_PWM_DRIVER_BLINK_EN is defined; otherwise blink_mask is ignored.
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int unsigned N_LEDS        = DEF_N_LEDS,
    parameter int unsigned PWM_BITS      = DEF_PWM_BITS,
    parameter int unsigned PRESCALE      = DEF_PRESCALE,
    parameter int unsigned BLINK_PERIODS = DEF_BLINK_PERIODS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_LEDS-1:0]   led_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [N_LEDS-1:0]   blink_mask,
    output logic [N_LEDS-1:0]   led_out,
    output logic                period_start
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap_c;

    logic [N_LEDS-1:0]   led_in_q, led_in_d;
    logic [N_LEDS-1:0]   led_out_q, led_out_d;
    logic [PWM_BITS-1:0] bright_sh_q, bright_sh_d;
    logic                pwm_on_c;
    logic [N_LEDS-1:0]   blink_kill_c;

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk          (clk),
        .reset        (reset),
        .pwm_cnt      (pwm_cnt),
        .wrap_c       (wrap_c),
        .period_start (period_start)
    );

`ifdef LED_PWM_DRIVER_BLINK_EN
    localparam int unsigned     BC_W    = cnt_width(BLINK_PERIODS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_PERIODS - 1);

    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    // Count PWM periods; flip the blink phase every BLINK_PERIODS periods.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wrap_c) begin
            if (blink_cnt_q == BC_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BC_W'(1);
            end
        end
    end

    // Blink registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_kill_c = blink_mask & {N_LEDS{blink_phase_q}};
`else
    logic unused_blink_c;

    // Blink not built: phase is constantly clear and the mask has no effect.
    assign unused_blink_c = (^blink_mask) ^ BLINK_PERIODS[0];
    assign blink_kill_c   = '0;
`endif

    // Input capture, period-aligned brightness shadow and output gating.
    always_comb begin
        led_in_d    = led_in;
        bright_sh_d = bright_sh_q;
        if (wrap_c) begin
            bright_sh_d = brightness;
        end
        pwm_on_c  = (&bright_sh_q) || (pwm_cnt < bright_sh_q);
        led_out_d = led_in_q & {N_LEDS{pwm_on_c}} & ~blink_kill_c;
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_in_q    <= '0;
            led_out_q   <= '0;
            bright_sh_q <= '0;
        end else begin
            led_in_q    <= led_in_d;
            led_out_q   <= led_out_d;
            bright_sh_q <= bright_sh_d;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with a cycle scoreboard and duty-count checks.
module tb_led_pwm_driver;

    localparam int unsigned NL  = 8;
    localparam int unsigned PB  = 8;
    localparam int unsigned PS  = 4;
    localparam int unsigned BP  = 2;
    localparam int unsigned PER = PS * (1 << PB);

    typedef struct packed {
        logic [7:0] led;
        logic       ps;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NL-1:0] led_in;
    logic [PB-1:0] brightness;
    logic [NL-1:0] blink_mask;
    logic [NL-1:0] led_out;
    logic          period_start;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model state: position within the 1024-cycle period.
    int         m_pos   = 0;
    logic [7:0] m_sh    = '0;
    logic [7:0] m_lq    = '0;
    logic [7:0] m_out   = '0;
    logic       m_ps    = 1'b0;
    int         m_bcnt  = 0;
    logic       m_phase = 1'b0;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .N_LEDS        (NL),
        .PWM_BITS      (PB),
        .PRESCALE      (PS),
        .BLINK_PERIODS (BP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .led_in       (led_in),
        .brightness   (brightness),
        .blink_mask   (blink_mask),
        .led_out      (led_out),
        .period_start (period_start)
    );

    // Advance the model one clock, push expectation, clock DUT, pop and compare.
    task automatic cycle();
        exp_t e;
        logic on;
        logic wrap;
        on = (m_sh == 8'hFF) || ((m_pos / int'(PS)) < int'(m_sh));
        if (reset) begin
            m_pos = 0; m_sh = '0; m_lq = '0; m_out = '0; m_ps = 1'b0;
            m_bcnt = 0; m_phase = 1'b0;
        end else begin
            wrap  = (m_pos == int'(PER) - 1);
            m_out = m_lq & {8{on}} & ~(blink_mask & {8{m_phase}});
            m_lq  = led_in;
            m_ps  = wrap;
            if (wrap) m_sh = brightness;
`ifdef LED_PWM_DRIVER_BLINK_EN
            if (wrap) begin
                if (m_bcnt == int'(BP) - 1) begin
                    m_bcnt  = 0;
                    m_phase = ~m_phase;
                end else begin
                    m_bcnt++;
                end
            end
`endif
            m_pos = (m_pos + 1) % int'(PER);
        end
        e.led = m_out;
        e.ps  = m_ps;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sbq.pop_front();
        n_vec++;
        assert (led_out === e.led) else begin
            n_err++;
            $error("FAIL sb_led_out cyc=%0d got=%h exp=%h", cyc, led_out, e.led);
        end
        n_vec++;
        assert (period_start === e.ps) else begin
            n_err++;
            $error("FAIL sb_period_start cyc=%0d got=%b exp=%b", cyc, period_start, e.ps);
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    // Run n cycles, counting samples where led_out equals pat.
    task automatic run_count(input int n, input logic [7:0] pat, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (led_out === pat) hits++;
        end
    endtask

    // Bounded wait for the next period_start pulse; k = cycles taken.
    task automatic wait_ps(input int max_cyc, output int k);
        logic found;
        found = 1'b0;
        k     = 0;
        while (!found && k < max_cyc) begin
            cycle();
            k++;
            if (period_start === 1'b1) found = 1'b1;
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL wait_period_start cyc=%0d got=timeout exp=pulse within %0d", cyc, max_cyc);
        end
    endtask

    initial begin
        int k;
        int hits;

        // Reset state
        reset = 1'b1; led_in = 8'hFF; brightness = 8'h80; blink_mask = 8'h00;
        repeat (3) cycle();
        check("rst_led_out", int'(led_out), 0);
        check("rst_period_start", int'(period_start), 0);
        reset = 1'b0;

        // First period dark, then 50 % duty
        run_count(int'(PER), 8'hFF, hits);
        check("p1_dark", hits, 0);
        check("ps_at_1024", int'(period_start), 1);
        run_count(int'(PER), 8'hFF, hits);
        check("p2_on_cycles", hits, 512);
        check("ps_at_2048", int'(period_start), 1);
        run_count(int'(PER), 8'hFF, hits);
        check("p3_on_cycles", hits, 512);

        // Full brightness: no dark cycle
        brightness = 8'hFF; led_in = 8'h5A;
        wait_ps(2 * int'(PER), k);
        check("ps_spacing", k, int'(PER));
        run_count(int'(PER), 8'h5A, hits);
        check("full_on_cycles", hits, int'(PER));

        // Two-cycle input latency
        led_in = 8'h00;
        repeat (3) cycle();
        led_in = 8'hA5;
        cycle();
        check("lat_t1", int'(led_out), 8'h00);
        cycle();
        check("lat_t2", int'(led_out), 8'hA5);

        // Mid-period brightness change takes effect next period
        brightness = 8'h40;
        wait_ps(2 * int'(PER), k);
        hits = 0;
        for (int i = 0; i < int'(PER); i++) begin
            if (i == 100) brightness = 8'hC0;
            cycle();
            if (led_out === 8'hA5) hits++;
        end
        check("shadow_cur_period", hits, 256);
        run_count(int'(PER), 8'hA5, hits);
        check("shadow_next_period", hits, 768);

        // One-cycle reset in the on-phase
        brightness = 8'h80;
        wait_ps(2 * int'(PER), k);
        repeat (10) cycle();
        check("pre_rst_on", int'(led_out), 8'hA5);
        reset = 1'b1;
        cycle();
        check("mid_rst_led_out", int'(led_out), 0);
        check("mid_rst_ps", int'(period_start), 0);
        reset = 1'b0;
        run_count(int'(PER) - 1, 8'h00, hits);
        check("post_rst_dark", hits, int'(PER) - 1);
        check("post_rst_no_ps", int'(period_start), 0);
        cycle();
        check("post_rst_ps_1024", int'(period_start), 1);

`ifdef LED_PWM_DRIVER_BLINK_EN
        // Blink: masked LEDs dark on alternate blink half-phases
        led_in = 8'hFF; brightness = 8'hFF; blink_mask = 8'h0F;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run_count(2 * int'(PER), 8'hFF, hits);
        run_count(2 * int'(PER), 8'hF0, hits);
        check("blink_phase1", hits, 2 * int'(PER));
        run_count(2 * int'(PER), 8'hFF, hits);
        check("blink_phase0", hits, 2 * int'(PER));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 Parameter N_LEDS, default 8: width of LED input/output vectors.
REQ-002 Parameter PWM_BITS, default 8: width of PWM counter and brightness.
REQ-003 Parameter PRESCALE, default 4: clk cycles per PWM tick, legal range 1 to 65535.
REQ-004 Parameter BLINK_PERIODS, default 64: PWM periods per blink half-phase, legal range 1 to 65535.
REQ-005 clk  in  1  sole clock; all state rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 led_in  in  N_LEDS  LED pattern from the LED PIO output port.
REQ-008 brightness  in  PWM_BITS  global duty request; all-ones means 100 %.
REQ-009 blink_mask  in  N_LEDS  per-LED blink enable, used only with blink compiled in.
REQ-010 led_out  out  N_LEDS  registered drive to board LED pins, active-high.
REQ-011 period_start  out  1  one-cycle pulse on the first cycle of each PWM period.

Function
REQ-012 led_in SHALL be registered once into led_q; led_out SHALL be registered; with PWM on and blink phase clear, an led_in change SHALL appear on led_out exactly 2 cycles later.
REQ-013 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick asserts when prescaler == PRESCALE-1; with PRESCALE=1, tick is asserted every cycle.
REQ-014 pwm_cnt SHALL increment on tick and wrap from 2^PWM_BITS-1 to 0; wrap = tick and pwm_cnt all-ones.
REQ-015 period_start SHALL be the registered wrap, i.e. high the cycle pwm_cnt becomes 0.
REQ-016 bright_sh (shadow) SHALL load brightness only on wrap; mid-period brightness changes SHALL NOT alter the current period.
REQ-017 pwm_on = (bright_sh all-ones) or (pwm_cnt < bright_sh); bright_sh=0 SHALL give led_out=0 constantly.
REQ-018 led_out next = led_q AND {N_LEDS{pwm_on}} AND NOT(blink_mask AND {N_LEDS{blink_phase}}).
REQ-019 Comparison SHALL be unsigned, PWM_BITS wide; no counter SHALL saturate or overflow beyond its wrap.

Reset
REQ-020 While reset is high at a clk edge, led_q, led_out, prescaler, pwm_cnt, bright_sh, period_start, blink counter and blink_phase SHALL all become 0.
REQ-021 Reset mid-period SHALL abort the period; the first cycle after deassertion starts prescaler=0, pwm_cnt=0 with bright_sh=0, so the first period after reset is fully dark.

Configuration
REQ-022 Macro LED_PWM_DRIVER_BLINK_EN defined: blink counter counts wraps 0..BLINK_PERIODS-1, toggling blink_phase on the wrap where count == BLINK_PERIODS-1, then reloading 0.
REQ-023 Macro undefined: blink counter and blink_phase SHALL not exist (blink_phase treated as constant 0), blink_mask SHALL be ignored, port list unchanged.

Structure
REQ-024 Package led_pwm_pkg SHALL hold default constants for N_LEDS, PWM_BITS, PRESCALE, BLINK_PERIODS.
REQ-025 Sub-module led_pwm_timebase SHALL contain prescaler, pwm_cnt and wrap/period_start generation; the top holds input/shadow/blink/output registers.

Verification (PRESCALE=4, PWM_BITS=8: period 1024 cycles)
REQ-026 Reset, led_in=0xFF, brightness=0x80 -> first period led_out=0x00; afterwards 512 cycles 0xFF then 512 cycles 0x00 per period, period_start every 1024 cycles.
REQ-027 brightness=0xFF, led_in=0x5A -> from the second period, led_out=0x5A continuously with no dark cycle.
REQ-028 brightness 0x40 -> 0xC0 at cycle 100 of a period -> that period on for 256 cycles; next period on for 768 cycles.
REQ-029 brightness=0xFF steady, led_in 0x00 -> 0xA5 at cycle T -> led_out=0xA5 at T+2, 0x00 at T+1.
REQ-030 Macro defined, BLINK_PERIODS=2, brightness=0xFF, led_in=0xFF, blink_mask=0x0F -> led_out alternates 0xFF/0xF0 every 2048 cycles.
REQ-031 reset pulsed 1 cycle mid on-phase -> led_out=0x00 next cycle, period_start absent until 1024 cycles after deassertion.
